// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC and
// the fetch state encoding.
package if_stage_pkg;

  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction RAM bus between the fetch stage (master) and inst RAM (slave).
//   inst_req_valid / inst_req_ready / inst_addr : one-word read request
//   inst_rsp_valid / inst_rdata                 : read data, one per accepted request
interface if_stage_if;
  import if_stage_pkg::*;

  logic                  inst_req_valid;
  logic                  inst_req_ready;
  logic [PC_W_DEF-1:0]   inst_addr;
  logic                  inst_rsp_valid;
  logic [INST_W-1:0]     inst_rdata;

  modport master (
    output inst_req_valid, inst_addr,
    input  inst_req_ready, inst_rsp_valid, inst_rdata
  );

  modport slave (
    input  inst_req_valid, inst_addr,
    output inst_req_ready, inst_rsp_valid, inst_rdata
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Holds the fetch PC, issues one word request at a
// time to inst RAM, buffers the returned word and presents {PC, Inst} to ID.
// A flush restarts fetch at flush_pc; a response already in flight is dropped.
// Ports:
//   clk, reset (async, active-low)
//   ibus        inst RAM request/response bus (master side)
//   flush       redirect fetch to flush_pc
//   halt        stop issuing new requests
//   right_valid {PC, Inst} valid to ID;  right_ready ID allowin
//   PC, Inst    presented instruction
//
// state  | meaning
// S_REQ  | request presented to inst RAM (unless halt/flush)
// S_WAIT | one request outstanding; drop_q marks it as flushed
// S_HOLD | word buffered, right_valid=1 until ID accepts it
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  if_stage_if.master        ibus,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              halt,
  output logic              right_valid,
  input  logic              right_ready,
  output logic [PC_W-1:0]   PC,
  output logic [INST_W-1:0] Inst
);

  fetch_state_e    state_q, state_nxt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            drop_q, drop_nxt;
  logic            req_fire;
  logic            load_buf;
  logic            flush_pc_unused;

  // Redirect targets are forced to word alignment, so the byte offset is ignored.
  assign flush_pc_unused = ^flush_pc[1:0];

  // reset is folded in so no request is seen while reset is held.
  assign ibus.inst_req_valid = reset & (state_q == S_REQ) & ~halt & ~flush;
  assign ibus.inst_addr      = pc_q;
  assign req_fire            = ibus.inst_req_valid & ibus.inst_req_ready;
  assign right_valid         = (state_q == S_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pc_q     <= {RESET_PC[PC_W-1:2], 2'b00};
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      PC       <= '0;
      Inst     <= '0;
    end else begin
      state_q <= state_nxt;
      drop_q  <= drop_nxt;
      if (flush)
        pc_q <= {flush_pc[PC_W-1:2], 2'b00};
      else if (req_fire)
        pc_q <= pc_q + PC_W'(4);
      if (req_fire)
        req_pc_q <= pc_q;
      if (load_buf) begin
        PC   <= req_pc_q;
        Inst <= ibus.inst_rdata;
      end
    end
  end

  // Responses outside S_WAIT (e.g. one left over from before a reset) are ignored.
  always_comb begin
    state_nxt = state_q;
    drop_nxt  = drop_q;
    load_buf  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (req_fire)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          if (ibus.inst_rsp_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end else if (ibus.inst_rsp_valid) begin
          if (drop_q) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = S_HOLD;
            load_buf  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (flush || right_ready)
          state_nxt = S_REQ;
      end
      default: begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        halt = 1'b0;
  logic        right_valid;
  logic        right_ready = 1'b0;
  logic [31:0] PC;
  logic [31:0] Inst;

  if_stage_if ibus();

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ibus        (ibus),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .halt        (halt),
    .right_valid (right_valid),
    .right_ready (right_ready),
    .PC          (PC),
    .Inst        (Inst)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_F00D;
  endfunction

  // ---------------- inst RAM model ----------------
  int          ram_lat = 1;
  bit          rand_lat = 1'b0;
  bit          ram_busy = 1'b0;
  int          ram_wait = 0;
  logic [31:0] ram_addr = '0;

  initial begin
    ibus.inst_req_ready = 1'b0;
    ibus.inst_rsp_valid = 1'b0;
    ibus.inst_rdata     = '0;
  end

  always @(posedge clk) begin
    #1;
    ibus.inst_rsp_valid = 1'b0;
    ibus.inst_rdata     = $urandom;
    if (ram_busy) begin
      if (ram_wait == 0) begin
        ibus.inst_rsp_valid = 1'b1;
        ibus.inst_rdata     = mem_word(ram_addr);
        ram_busy            = 1'b0;
      end else begin
        ram_wait--;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] ost_q[$];
  bit          live_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] deliv_q[$];
  bit          have_item, want_req, live;
  logic [31:0] a;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_right_valid", {31'b0, right_valid}, 32'd0);
      chk("rst_req_valid", {31'b0, ibus.inst_req_valid}, 32'd0);
      ost_q.delete();
      live_q.delete();
      exp_q.delete();
      exp_addr = RST_PC;
    end else begin
      have_item = (exp_q.size() != 0);
      chk("right_valid", {31'b0, right_valid}, {31'b0, have_item});
      if (right_valid && have_item) begin
        chk("out_pc", PC, exp_q[0][63:32]);
        chk("out_inst", Inst, exp_q[0][31:0]);
      end
      want_req = !halt && !flush && (ost_q.size() == 0) && !have_item;
      chk("req_valid", {31'b0, ibus.inst_req_valid}, {31'b0, want_req});
      if (ibus.inst_req_valid)
        chk("req_addr", ibus.inst_addr, exp_addr);

      if (ibus.inst_rsp_valid && ost_q.size() != 0) begin
        a    = ost_q.pop_front();
        live = live_q.pop_front();
        if (live && !flush)
          exp_q.push_back({a, mem_word(a)});
      end
      if (right_valid && right_ready && !flush && have_item) begin
        void'(exp_q.pop_front());
        deliv_q.push_back(PC);
      end
      if (ibus.inst_req_valid && ibus.inst_req_ready) begin
        ost_q.push_back(ibus.inst_addr);
        live_q.push_back(1'b1);
        exp_addr = exp_addr + 32'd4;
        ram_busy = 1'b1;
        ram_addr = ibus.inst_addr;
        ram_wait = (rand_lat ? $urandom_range(1, 4) : ram_lat) - 1;
      end
      if (flush) begin
        exp_addr = {flush_pc[31:2], 2'b00};
        foreach (live_q[i]) live_q[i] = 1'b0;
        exp_q.delete();
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_fire(input string tag);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ibus.inst_req_valid && ibus.inst_req_ready) return;
    end
    chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_deliv(input int target, input string tag);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (deliv_q.size() >= target) return;
    end
    chk(tag, 32'd0, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int n0;
  logic [31:0] xpc;

  initial begin
    // Reset release, RAM always ready, 1-cycle response
    ibus.inst_req_ready = 1'b1;
    right_ready = 1'b1;
    ram_lat = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("first_req_valid", {31'b0, ibus.inst_req_valid}, 32'd1);
    chk("first_addr", ibus.inst_addr, RST_PC);
    wait_deliv(3, "timeout_first3");
    chk("deliv0", deliv_q[0], 32'h1c00_0000);
    chk("deliv1", deliv_q[1], 32'h1c00_0004);
    chk("deliv2", deliv_q[2], 32'h1c00_0008);

    // ID stalls for 5 cycles in S_HOLD
    step();
    right_ready = 1'b0;
    for (int n = 0; n < 40 && !right_valid; n++) @(negedge clk);
    n0  = deliv_q.size();
    xpc = RST_PC + 32'(4 * n0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, right_valid}, 32'd1);
      chk("stall_pc", PC, xpc);
      chk("stall_inst", Inst, mem_word(xpc));
      chk("stall_noreq", {31'b0, ibus.inst_req_valid}, 32'd0);
    end
    step();
    right_ready = 1'b1;

    // Flush during S_WAIT, response 3 cycles later is dropped
    ram_lat = 4;
    wait_fire("timeout_fire_t3");
    step();
    flush = 1'b1;
    flush_pc = 32'h1c00_0100;
    step();
    flush = 1'b0;
    n0 = deliv_q.size();
    wait_fire("timeout_fire_t3b");
    chk("flush_wait_addr", ibus.inst_addr, 32'h1c00_0100);
    wait_deliv(n0 + 1, "timeout_deliv_t3");
    chk("flush_wait_deliv", deliv_q[n0], 32'h1c00_0100);

    // Flush in the same cycle as the response, unaligned target
    ram_lat = 2;
    wait_fire("timeout_fire_t4");
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #2;
      if (ibus.inst_rsp_valid) break;
    end
    flush = 1'b1;
    flush_pc = 32'h1c00_0102;
    @(negedge clk);
    chk("flush_rsp_noreq", {31'b0, ibus.inst_req_valid}, 32'd0);
    step();
    flush = 1'b0;
    n0 = deliv_q.size();
    @(negedge clk);
    chk("flush_rsp_req", {31'b0, ibus.inst_req_valid}, 32'd1);
    chk("flush_rsp_addr", ibus.inst_addr, 32'h1c00_0100);
    wait_deliv(n0 + 1, "timeout_deliv_t4");
    chk("flush_rsp_deliv", deliv_q[n0], 32'h1c00_0100);

    // PC wrap, and halt while a request is outstanding
    ram_lat = 3;
    step();
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    n0 = deliv_q.size();
    wait_fire("timeout_fire_t5");
    chk("wrap_addr", ibus.inst_addr, 32'hFFFF_FFFC);
    step();
    halt = 1'b1;
    wait_deliv(n0 + 1, "timeout_deliv_t5");
    chk("halt_deliv", deliv_q[n0], 32'hFFFF_FFFC);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_noreq", {31'b0, ibus.inst_req_valid}, 32'd0);
    end
    step();
    halt = 1'b0;
    @(negedge clk);
    chk("wrap_req", {31'b0, ibus.inst_req_valid}, 32'd1);
    chk("wrap_next_addr", ibus.inst_addr, 32'h0000_0000);

    // Reset asserted mid-S_WAIT; late response must be ignored
    ram_lat = 4;
    wait_fire("timeout_fire_t6");
    step();
    ibus.inst_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_async_rv", {31'b0, right_valid}, 32'd0);
    chk("rst_async_req", {31'b0, ibus.inst_req_valid}, 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int n = 0; n < 20 && ram_busy; n++) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("late_rsp_rv", {31'b0, right_valid}, 32'd0);
    end
    step();
    ibus.inst_req_ready = 1'b1;
    n0 = deliv_q.size();
    @(negedge clk);
    chk("restart_req", {31'b0, ibus.inst_req_valid}, 32'd1);
    chk("restart_addr", ibus.inst_addr, RST_PC);
    wait_deliv(n0 + 1, "timeout_deliv_t6");
    chk("restart_deliv", deliv_q[n0], RST_PC);

    // Randomized traffic checked by the reference model
    rand_lat = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      step();
      ibus.inst_req_ready = ($urandom_range(0, 3) != 0);
      right_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      flush_pc = $urandom;
      halt = ($urandom_range(0, 15) == 0);
    end
    step();
    flush = 1'b0;
    halt = 1'b0;
    ibus.inst_req_ready = 1'b1;
    right_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
